// File: rtl/scr1_pipe_mprf_wb_ctrl_pkg.sv
// Shared types and constants for the MPRF write-back controller slice.
// Optional feature macro used by this slice: SCR1_MPRF_WB_BYPASS_EN.
package scr1_pipe_mprf_wb_ctrl_pkg;

  localparam int SCR1_MPRF_AWIDTH = 5;
  localparam int SCR1_XLEN        = 32;

  // Write-back source currently owning the MPRF write port
  typedef enum logic {
    SCR1_MPRF_WB_SRC_EXU = 1'b0,
    SCR1_MPRF_WB_SRC_LSU = 1'b1
  } type_scr1_mprf_wb_src_e;

  // Number of consecutive EXU denials after which EXU beats LSU
  localparam logic [1:0] SCR1_MPRF_WB_STARV_LIM = 2'd3;

endpackage : scr1_pipe_mprf_wb_ctrl_pkg

// File: rtl/scr1_pipe_mprf_wb_ctrl_if.sv
// Signal bundle between EXU/LSU/MPRF and the write-back controller.
//
// Handshake: a source raises *_wb_req_i with addr/data and holds all three
// stable until it sees its *_wb_rdy_o high; the write happens in the cycle
// where req and rdy are both high. rdy is combinational and may drop while
// req is held (source lost arbitration); it never rises without req.
interface scr1_pipe_mprf_wb_ctrl_if #(
  parameter int AWIDTH = scr1_pipe_mprf_wb_ctrl_pkg::SCR1_MPRF_AWIDTH,
  parameter int XLEN   = scr1_pipe_mprf_wb_ctrl_pkg::SCR1_XLEN
);
  logic              exu_wb_req_i;
  logic [AWIDTH-1:0] exu_wb_addr_i;
  logic [XLEN-1:0]   exu_wb_data_i;
  logic              exu_wb_rdy_o;
  logic              lsu_wb_req_i;
  logic [AWIDTH-1:0] lsu_wb_addr_i;
  logic [XLEN-1:0]   lsu_wb_data_i;
  logic              lsu_wb_rdy_o;
  logic              issue_vd_i;
  logic [AWIDTH-1:0] issue_rd_addr_i;
  logic [AWIDTH-1:0] exu_rs1_addr_i;
  logic [AWIDTH-1:0] exu_rs2_addr_i;
  logic              hazard_o;
  logic              mprf_w_req_o;
  logic [AWIDTH-1:0] mprf_rd_addr_o;
  logic [XLEN-1:0]   mprf_rd_data_o;
  logic              byp_rs1_vd_o;
  logic              byp_rs2_vd_o;
  logic [XLEN-1:0]   byp_data_o;

  // Pipeline side: EXU, LSU and MPRF as seen from outside the controller
  modport master (
    output exu_wb_req_i, exu_wb_addr_i, exu_wb_data_i,
    output lsu_wb_req_i, lsu_wb_addr_i, lsu_wb_data_i,
    output issue_vd_i, issue_rd_addr_i, exu_rs1_addr_i, exu_rs2_addr_i,
    input  exu_wb_rdy_o, lsu_wb_rdy_o, hazard_o,
    input  mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o,
    input  byp_rs1_vd_o, byp_rs2_vd_o, byp_data_o
  );

  // Controller side
  modport slave (
    input  exu_wb_req_i, exu_wb_addr_i, exu_wb_data_i,
    input  lsu_wb_req_i, lsu_wb_addr_i, lsu_wb_data_i,
    input  issue_vd_i, issue_rd_addr_i, exu_rs1_addr_i, exu_rs2_addr_i,
    output exu_wb_rdy_o, lsu_wb_rdy_o, hazard_o,
    output mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o,
    output byp_rs1_vd_o, byp_rs2_vd_o, byp_data_o
  );
endinterface : scr1_pipe_mprf_wb_ctrl_if

// File: rtl/scr1_pipe_mprf_wb_ctrl_sb.sv
// Pending-write scoreboard for long-latency destinations.
// One bit per architectural register; x0 is never marked pending.
// Lookups: rs1, rs2, and one write-address port that covers both the
// WAW check of a newly issued rd and the EXU write-back destination.
module scr1_pipe_mprf_sb #(
  parameter int AWIDTH = 5
) (
  input  logic              rst_n,
  input  logic              clk,
  input  logic              set_i,
  input  logic [AWIDTH-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [AWIDTH-1:0] clr_addr_i,
  input  logic [AWIDTH-1:0] rs1_addr_i,
  input  logic [AWIDTH-1:0] rs2_addr_i,
  input  logic              wa_iss_vd_i,
  input  logic [AWIDTH-1:0] wa_iss_addr_i,
  input  logic              wa_exu_vd_i,
  input  logic [AWIDTH-1:0] wa_exu_addr_i,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  output logic              wa_pend_o
);
  localparam int NREGS = 2 ** AWIDTH;

  // Bit 0 is reset to 0 and never written, so x0 always looks free
  logic [NREGS-1:0] pend;

  // Clear on LSU write, then set on issue; the later assignment wins a tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      if (clr_i && (clr_addr_i != '0)) pend[clr_addr_i] <= 1'b0;
      if (set_i && (set_addr_i != '0)) pend[set_addr_i] <= 1'b1;
    end
  end

  assign rs1_pend_o = pend[rs1_addr_i];
  assign rs2_pend_o = pend[rs2_addr_i];
  assign wa_pend_o  = (wa_iss_vd_i & pend[wa_iss_addr_i])
                    | (wa_exu_vd_i & pend[wa_exu_addr_i]);

endmodule : scr1_pipe_mprf_sb

// File: rtl/scr1_pipe_mprf_wb_ctrl.sv
// MPRF write-back controller: arbitrates EXU and LSU write-backs onto the
// single MPRF write port (LSU first, EXU starvation guard), tracks pending
// long-latency destinations and raises the EXU stall hazard.
// Optional feature macro: SCR1_MPRF_WB_BYPASS_EN (forward the LSU write data
// to EXU sources in the write cycle instead of stalling one more cycle).
module scr1_pipe_mprf_wb_ctrl
  import scr1_pipe_mprf_wb_ctrl_pkg::*;
#(
  parameter int AWIDTH = SCR1_MPRF_AWIDTH,
  parameter int XLEN   = SCR1_XLEN
) (
  input logic                     rst_n,
  input logic                     clk,
  scr1_pipe_mprf_wb_ctrl_if.slave wb
);
  logic                   exu_gnt;
  logic                   lsu_gnt;
  logic [1:0]             starv_cnt;
  type_scr1_mprf_wb_src_e wb_src;
  logic [AWIDTH-1:0]      w_addr;
  logic [XLEN-1:0]        w_data;
  logic                   rs1_pend;
  logic                   rs2_pend;
  logic                   wa_pend;

  // Fixed priority LSU over EXU, unless EXU has been denied the limit times
  always_comb begin
    exu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (wb.exu_wb_req_i && wb.lsu_wb_req_i) begin
      if (starv_cnt == SCR1_MPRF_WB_STARV_LIM) exu_gnt = 1'b1;
      else                                     lsu_gnt = 1'b1;
    end else begin
      exu_gnt = wb.exu_wb_req_i;
      lsu_gnt = wb.lsu_wb_req_i;
    end
  end

  // Count consecutive EXU denials; any cycle without a denial restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starv_cnt <= 2'd0;
    end else if (wb.exu_wb_req_i && !exu_gnt) begin
      if (starv_cnt != SCR1_MPRF_WB_STARV_LIM) starv_cnt <= starv_cnt + 2'd1;
    end else begin
      starv_cnt <= 2'd0;
    end
  end

  assign wb_src = lsu_gnt ? SCR1_MPRF_WB_SRC_LSU : SCR1_MPRF_WB_SRC_EXU;

  // Steer the granted source onto the MPRF port; idle port drives zeros
  always_comb begin
    w_addr = '0;
    w_data = '0;
    if (exu_gnt || lsu_gnt) begin
      case (wb_src)
        SCR1_MPRF_WB_SRC_LSU: begin
          w_addr = wb.lsu_wb_addr_i;
          w_data = wb.lsu_wb_data_i;
        end
        default: begin
          w_addr = wb.exu_wb_addr_i;
          w_data = wb.exu_wb_data_i;
        end
      endcase
    end
  end

  assign wb.exu_wb_rdy_o   = exu_gnt;
  assign wb.lsu_wb_rdy_o   = lsu_gnt;
  assign wb.mprf_w_req_o   = exu_gnt | lsu_gnt;
  assign wb.mprf_rd_addr_o = w_addr;
  assign wb.mprf_rd_data_o = w_data;

  scr1_pipe_mprf_sb #(
    .AWIDTH (AWIDTH)
  ) i_sb (
    .rst_n         (rst_n),
    .clk           (clk),
    .set_i         (wb.issue_vd_i),
    .set_addr_i    (wb.issue_rd_addr_i),
    .clr_i         (lsu_gnt),
    .clr_addr_i    (wb.lsu_wb_addr_i),
    .rs1_addr_i    (wb.exu_rs1_addr_i),
    .rs2_addr_i    (wb.exu_rs2_addr_i),
    .wa_iss_vd_i   (wb.issue_vd_i),
    .wa_iss_addr_i (wb.issue_rd_addr_i),
    .wa_exu_vd_i   (wb.exu_wb_req_i),
    .wa_exu_addr_i (wb.exu_wb_addr_i),
    .rs1_pend_o    (rs1_pend),
    .rs2_pend_o    (rs2_pend),
    .wa_pend_o     (wa_pend)
  );

`ifdef SCR1_MPRF_WB_BYPASS_EN
  logic byp_rs1;
  logic byp_rs2;

  // A source being written by the LSU this cycle takes the LSU data directly
  always_comb begin
    byp_rs1 = lsu_gnt && (wb.lsu_wb_addr_i == wb.exu_rs1_addr_i)
                      && (wb.exu_rs1_addr_i != '0);
    byp_rs2 = lsu_gnt && (wb.lsu_wb_addr_i == wb.exu_rs2_addr_i)
                      && (wb.exu_rs2_addr_i != '0);
  end

  assign wb.byp_rs1_vd_o = byp_rs1;
  assign wb.byp_rs2_vd_o = byp_rs2;
  assign wb.byp_data_o   = (byp_rs1 || byp_rs2) ? wb.lsu_wb_data_i : '0;
  assign wb.hazard_o     = (rs1_pend & ~byp_rs1) | (rs2_pend & ~byp_rs2) | wa_pend;
`else
  // Without forwarding the pending bit must clear before EXU may proceed
  assign wb.byp_rs1_vd_o = 1'b0;
  assign wb.byp_rs2_vd_o = 1'b0;
  assign wb.byp_data_o   = '0;
  assign wb.hazard_o     = rs1_pend | rs2_pend | wa_pend;
`endif

endmodule : scr1_pipe_mprf_wb_ctrl

// File: tb/tb_scr1_pipe_mprf_wb_ctrl.sv
// Bench for the MPRF write-back controller: scenario tasks with inline
// checks plus an MPRF-write scoreboard fed from an expected queue.
module tb_scr1_pipe_mprf_wb_ctrl;
  localparam int AW = 5;
  localparam int XW = 32;
  localparam int W  = AW + XW;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  scr1_pipe_mprf_wb_ctrl_if #(.AWIDTH(AW), .XLEN(XW)) wb ();

  scr1_pipe_mprf_wb_ctrl #(.AWIDTH(AW), .XLEN(XW)) dut (
    .rst_n (rst_n),
    .clk   (clk),
    .wb    (wb)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every MPRF write must match the oldest expected write
  always @(negedge clk) begin
    #2;
    if (wb.mprf_w_req_o === 1'b1) begin
      mon_act = {wb.mprf_rd_addr_o, wb.mprf_rd_data_o};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mprf_write_unexpected act=%h exp=none t=%0t", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL mprf_write act=%h exp=%h t=%0t", mon_act, mon_exp, $time);
        end
      end
    end
  end

  task automatic drive_idle();
    wb.exu_wb_req_i    = 1'b0;
    wb.exu_wb_addr_i   = '0;
    wb.exu_wb_data_i   = '0;
    wb.lsu_wb_req_i    = 1'b0;
    wb.lsu_wb_addr_i   = '0;
    wb.lsu_wb_data_i   = '0;
    wb.issue_vd_i      = 1'b0;
    wb.issue_rd_addr_i = '0;
    wb.exu_rs1_addr_i  = '0;
    wb.exu_rs2_addr_i  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    wb.exu_rs1_addr_i = 5'd3;
    @(negedge clk); #1;
    checks++;
    if ({wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o, wb.hazard_o, wb.mprf_w_req_o, wb.mprf_rd_addr_o,
         wb.mprf_rd_data_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs act: rdy=%b%b haz=%b wreq=%b addr=%h data=%h byp=%b%b bdata=%h exp all 0",
               wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o, wb.hazard_o, wb.mprf_w_req_o, wb.mprf_rd_addr_o,
               wb.mprf_rd_data_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lone_requesters();
    logic [AW-1:0] a;
    logic [XW-1:0] d;
    @(negedge clk);
    drive_idle();
    wb.exu_wb_req_i  = 1'b1;
    wb.exu_wb_addr_i = 5'd5;
    wb.exu_wb_data_i = 32'hDEADBEEF;
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    #1;
    checks++;
    if ({wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o, wb.mprf_w_req_o} !== 3'b101) begin
      failures++;
      $display("FAIL exu_only_rdy act=%b exp=101", {wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o, wb.mprf_w_req_o});
    end
    checks++;
    if ({wb.mprf_rd_addr_o, wb.mprf_rd_data_o} !== {5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL exu_only_port act=%h/%h exp=05/deadbeef", wb.mprf_rd_addr_o, wb.mprf_rd_data_o);
    end
    for (int i = 0; i < 6; i++) begin
      a = 5'($urandom_range(1, 31));
      d = $urandom;
      @(negedge clk);
      drive_idle();
      if (i % 2 == 0) begin
        wb.exu_wb_req_i = 1'b1; wb.exu_wb_addr_i = a; wb.exu_wb_data_i = d;
      end else begin
        wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = a; wb.lsu_wb_data_i = d;
      end
      exp_q.push_back({a, d});
      #1;
      checks++;
      if ({wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL lone_rdy[%0d] act=%b exp=%b", i, {wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o},
                 (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
  endtask

  // Both sources held; EXU expected to win only in cycle exu_cyc
  task automatic test_contention(input int ncyc, input int exu_cyc);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive_idle();
      wb.exu_wb_req_i = 1'b1; wb.exu_wb_addr_i = 5'd3; wb.exu_wb_data_i = 32'hE0E0_0003;
      wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = 5'd4; wb.lsu_wb_data_i = 32'h1515_0004;
      if (k == exu_cyc) exp_q.push_back({5'd3, 32'hE0E0_0003});
      else              exp_q.push_back({5'd4, 32'h1515_0004});
      #1;
      checks++;
      if ({wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o} !== ((k == exu_cyc) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL contention_rdy[%0d] act=%b exp=%b", k, {wb.exu_wb_rdy_o, wb.lsu_wb_rdy_o},
                 (k == exu_cyc) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_hazard_bypass();
    @(negedge clk); drive_idle();
    wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd7; wb.exu_rs1_addr_i = 5'd7;
    #1; checks++;
    if (wb.hazard_o !== 1'b0) begin
      failures++; $display("FAIL haz_issue_cycle act=%b exp=0", wb.hazard_o);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd7;
      #1; checks++;
      if (wb.hazard_o !== 1'b1) begin
        failures++; $display("FAIL haz_pending[%0d] act=%b exp=1", k, wb.hazard_o);
      end
    end
    @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd7;
    wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = 5'd7; wb.lsu_wb_data_i = 32'hC0FFEE07;
    exp_q.push_back({5'd7, 32'hC0FFEE07});
    #1; checks++;
`ifdef SCR1_MPRF_WB_BYPASS_EN
    if ({wb.hazard_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o} !== {3'b010, 32'hC0FFEE07}) begin
      failures++;
      $display("FAIL haz_lsu_write_cycle act=haz%b byp%b%b %h exp=haz0 byp10 c0ffee07",
               wb.hazard_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o);
    end
`else
    if ({wb.hazard_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o} !== {3'b100, 32'h0}) begin
      failures++;
      $display("FAIL haz_lsu_write_cycle act=haz%b byp%b%b %h exp=haz1 byp00 00000000",
               wb.hazard_o, wb.byp_rs1_vd_o, wb.byp_rs2_vd_o, wb.byp_data_o);
    end
`endif
    @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd7;
    #1; checks++;
    if ({wb.hazard_o, wb.byp_rs1_vd_o} !== 2'b00) begin
      failures++; $display("FAIL haz_after_write act=%b exp=00", {wb.hazard_o, wb.byp_rs1_vd_o});
    end
  endtask

  task automatic test_set_clear_same();
    @(negedge clk); drive_idle();
    wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd9;
    wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = 5'd9; wb.lsu_wb_data_i = 32'h0000_0909;
    exp_q.push_back({5'd9, 32'h0000_0909});
    @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd9;
    #1; checks++;
    if (wb.hazard_o !== 1'b1) begin
      failures++; $display("FAIL set_wins_pend9 act=%b exp=1", wb.hazard_o);
    end
    @(negedge clk); drive_idle();
    wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = 5'd9; wb.lsu_wb_data_i = 32'h0000_0999;
    exp_q.push_back({5'd9, 32'h0000_0999});
    @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd9;
    #1; checks++;
    if (wb.hazard_o !== 1'b0) begin
      failures++; $display("FAIL clear_pend9 act=%b exp=0", wb.hazard_o);
    end
  endtask

  task automatic test_x0();
    @(negedge clk); drive_idle();
    wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd0;
    wb.exu_wb_req_i = 1'b1; wb.exu_wb_addr_i = 5'd0; wb.exu_wb_data_i = 32'h0000_1234;
    exp_q.push_back({5'd0, 32'h0000_1234});
    #1; checks++;
    if ({wb.exu_wb_rdy_o, wb.mprf_w_req_o, wb.hazard_o} !== 3'b110) begin
      failures++;
      $display("FAIL x0_forward act=%b exp=110", {wb.exu_wb_rdy_o, wb.mprf_w_req_o, wb.hazard_o});
    end
    @(negedge clk); drive_idle();
    wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd0;
    #1; checks++;
    if (wb.hazard_o !== 1'b0) begin
      failures++; $display("FAIL x0_never_pending act=%b exp=0", wb.hazard_o);
    end
  endtask

  task automatic test_waw_exu();
    @(negedge clk); drive_idle(); wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd12;
    @(negedge clk); drive_idle(); wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'd12;
    #1; checks++;
    if (wb.hazard_o !== 1'b1) begin
      failures++; $display("FAIL waw_issue act=%b exp=1", wb.hazard_o);
    end
    @(negedge clk); drive_idle();
    wb.exu_wb_req_i = 1'b1; wb.exu_wb_addr_i = 5'd12; wb.exu_wb_data_i = 32'h0000_0C0C;
    exp_q.push_back({5'd12, 32'h0000_0C0C});
    #1; checks++;
    if ({wb.hazard_o, wb.exu_wb_rdy_o} !== 2'b11) begin
      failures++; $display("FAIL waw_exu_wb act=%b exp=11", {wb.hazard_o, wb.exu_wb_rdy_o});
    end
    @(negedge clk); drive_idle(); wb.exu_rs2_addr_i = 5'd12;
    #1; checks++;
    if (wb.hazard_o !== 1'b1) begin
      failures++; $display("FAIL haz_rs2 act=%b exp=1", wb.hazard_o);
    end
    @(negedge clk); drive_idle();
    wb.lsu_wb_req_i = 1'b1; wb.lsu_wb_addr_i = 5'd12; wb.lsu_wb_data_i = 32'h0000_C12C;
    exp_q.push_back({5'd12, 32'h0000_C12C});
    @(negedge clk); drive_idle(); wb.exu_rs2_addr_i = 5'd12;
    #1; checks++;
    if (wb.hazard_o !== 1'b0) begin
      failures++; $display("FAIL haz_rs2_cleared act=%b exp=0", wb.hazard_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 8; r < 12; r++) begin
      @(negedge clk); drive_idle(); wb.issue_vd_i = 1'b1; wb.issue_rd_addr_i = 5'(r);
    end
    @(negedge clk); drive_idle(); wb.exu_rs1_addr_i = 5'd8; wb.exu_rs2_addr_i = 5'd11;
    #1; checks++;
    if (wb.hazard_o !== 1'b1) begin
      failures++; $display("FAIL pre_reset_pending act=%b exp=1", wb.hazard_o);
    end
    // Two LSU wins leave the starvation count at 2
    test_contention(2, 99);
    @(negedge clk);
    rst_n = 1'b0;
    wb.exu_rs1_addr_i = 5'd8; wb.exu_rs2_addr_i = 5'd11;
    exp_q.push_back({5'd4, 32'h1515_0004});
    #1; checks++;
    if ({wb.hazard_o, wb.lsu_wb_rdy_o} !== 2'b01) begin
      failures++; $display("FAIL reset_mid_clear act=%b exp=01", {wb.hazard_o, wb.lsu_wb_rdy_o});
    end
    // Released at the next negedge inside the task; count restarts at 0
    test_contention(4, 3);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_lone_requesters();
    test_contention(5, 3);
    test_hazard_bypass();
    test_set_clear_same();
    test_x0();
    test_waw_exu();
    test_reset_mid();
    @(negedge clk); drive_idle();
    @(negedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL writes_missing act=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_scr1_pipe_mprf_wb_ctrl
